instr_source_unit: RTL and testbench

//  Fetch-side consumer of the instruction-source controls (instr_mode, instr_ext) that the bench drives.

---
 rtl/instr_source_unit.sv | 148 ++++++++++++++
 tb/tb_instr_source_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_source_unit.sv
// Fetch-side instruction source: issues one registered instruction per cycle from
// instruction memory or from a FIFO of injected words, and owns the fetch PC.
module instr_source_unit #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            instr_mode,
   input  logic [31:0]                     instr_ext,
   input  logic                            ext_valid,
   output logic                            ext_ready,
   output logic [31:0]                     imem_addr,
   input  logic [31:0]                     imem_rdata,
   input  logic                            fetch_stall,
   input  logic                            flush,
   input  logic [31:0]                     flush_pc,
   output logic [31:0]                     if_pc,
   output logic [31:0]                     if_instr,
   output logic                            if_valid,
   output logic                            cur_mode,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic [1:0]                      fsm_state
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_MEM    = 2'd0,
      ST_EXT    = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   // Injection handshake: a word is taken on any edge where ext_valid && ext_ready.
   state_t        state_q, state_d;
   logic          cur_mode_q, cur_mode_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   if_pc_q, if_pc_d;
   logic [31:0]   if_instr_q, if_instr_d;
   logic          if_valid_q, if_valid_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic          push, pop, fifo_empty;

   assign ext_ready  = (count_q < DEPTH_C);
   assign fifo_empty = (count_q == '0);
   assign push       = ext_valid && ext_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_MEM;
         cur_mode_q <= 1'b0;
         pc_q       <= RESET_PC;
         if_pc_q    <= RESET_PC;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cur_mode_q <= cur_mode_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= instr_ext;
   end

   // A flush never moves the FSM out of MEM/EXT, but SWITCH always completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_MEM:    if (!flush && !fetch_stall && instr_mode) state_d = ST_SWITCH;
         ST_EXT:    if (!flush && !fetch_stall && fifo_empty && !instr_mode) state_d = ST_SWITCH;
         ST_SWITCH: state_d = cur_mode_q ? ST_MEM : ST_EXT;
         default:   state_d = ST_MEM;
      endcase
   end

   always_comb begin
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      cur_mode_d = cur_mode_q;
      pop        = 1'b0;
      if (state_q == ST_SWITCH) cur_mode_d = ~cur_mode_q;
      if (flush) begin
         pc_d       = flush_pc;
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
      end else begin
         case (state_q)
            ST_MEM: begin
               if (!fetch_stall) begin
                  if (!instr_mode) begin
                     if_instr_d = imem_rdata;
                     if_pc_d    = pc_q;
                     if_valid_d = 1'b1;
                     pc_d       = pc_q + 32'd4;
                  end else begin
                     if_instr_d = NOP_INSTR;
                     if_valid_d = 1'b0;
                  end
               end
            end
            ST_EXT: begin
               if (!fetch_stall) begin
                  if (!fifo_empty) begin
                     pop        = 1'b1;
                     if_instr_d = fifo_mem[rd_ptr_q];
                     if_pc_d    = pc_q;
                     if_valid_d = 1'b1;
                     pc_d       = pc_q + 32'd4;
                  end else begin
                     if_instr_d = NOP_INSTR;
                     if_valid_d = 1'b0;
                  end
               end
            end
            default: begin
               if_instr_d = NOP_INSTR;
               if_valid_d = 1'b0;
            end
         endcase
      end
   end

   assign imem_addr  = pc_q;
   assign if_pc      = if_pc_q;
   assign if_instr   = if_instr_q;
   assign if_valid   = if_valid_q;
   assign cur_mode   = cur_mode_q;
   assign fifo_count = count_q;
   assign fsm_state  = state_q;

endmodule

// File: tb/tb_instr_source_unit.sv
// Directed bench for instr_source_unit: reset, memory fetch, injection with stall,
// FIFO full, mode switch drain, flush vs stall, PC wrap and mid-run reset.
module tb_instr_source_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_mode = 1'b0;
   logic [31:0] instr_ext = '0;
   logic        ext_valid = 1'b0;
   logic        ext_ready;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        fetch_stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        cur_mode;
   logic [2:0]  fifo_count;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] words [5];

   localparam logic [1:0] S_MEM = 2'd0, S_EXT = 2'd1, S_SW = 2'd2;

   instr_source_unit dut (
      .clk(clk), .reset(reset), .instr_mode(instr_mode), .instr_ext(instr_ext),
      .ext_valid(ext_valid), .ext_ready(ext_ready), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .fetch_stall(fetch_stall), .flush(flush),
      .flush_pc(flush_pc), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
      .cur_mode(cur_mode), .fifo_count(fifo_count), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // Instruction memory model: a fixed word at 0, address-tagged words elsewhere.
   assign imem_rdata = (imem_addr == 32'h0) ? 32'h0050_0093 : (32'hA000_0000 ^ imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_issue(input string tag, input logic [31:0] pc, input logic [31:0] ins);
      check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
      check({tag, "_pc"}, if_pc, pc);
      check({tag, "_instr"}, if_instr, ins);
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
      check({tag, "_instr"}, if_instr, 32'h0000_0013);
   endtask

   initial begin
      words[0] = 32'h0030_0193; words[1] = 32'h0040_0213; words[2] = 32'h0050_0293;
      words[3] = 32'h0060_0313; words[4] = 32'h0070_0393;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // T1 reset state
      check_bubble("t1");
      check("t1_pc", imem_addr, 32'h0);
      check("t1_if_pc", if_pc, 32'h0);
      check("t1_count", {29'b0, fifo_count}, 32'd0);
      check("t1_ready", {31'b0, ext_ready}, 32'd1);
      check("t1_mode", {31'b0, cur_mode}, 32'd0);
      check("t1_state", {30'b0, fsm_state}, {30'b0, S_MEM});

      // T2 memory fetch
      tick();
      check_issue("t2_a", 32'h0, 32'h0050_0093);
      check("t2_pc", imem_addr, 32'h4);
      tick();
      check_issue("t2_b", 32'h4, 32'hA000_0004);

      // T3 injection with stall
      instr_mode = 1'b1; ext_valid = 1'b1; instr_ext = 32'h0010_0113;
      tick();
      check_bubble("t3_req");
      check("t3_req_if_pc", if_pc, 32'h4);
      check("t3_req_state", {30'b0, fsm_state}, {30'b0, S_SW});
      check("t3_req_mode", {31'b0, cur_mode}, 32'd0);
      check("t3_req_count", {29'b0, fifo_count}, 32'd1);
      instr_ext = 32'h0020_8193;
      tick();
      check_bubble("t3_sw");
      check("t3_sw_state", {30'b0, fsm_state}, {30'b0, S_EXT});
      check("t3_sw_mode", {31'b0, cur_mode}, 32'd1);
      check("t3_sw_count", {29'b0, fifo_count}, 32'd2);
      ext_valid = 1'b0;
      tick();
      check_issue("t3_w0", 32'h8, 32'h0010_0113);
      check("t3_w0_count", {29'b0, fifo_count}, 32'd1);
      fetch_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_issue("t3_hold", 32'h8, 32'h0010_0113);
         check("t3_hold_count", {29'b0, fifo_count}, 32'd1);
         check("t3_hold_ready", {31'b0, ext_ready}, 32'd1);
      end
      check("t3_hold_pc", imem_addr, 32'hC);
      fetch_stall = 1'b0;
      tick();
      check_issue("t3_w1", 32'hC, 32'h0020_8193);
      check("t3_w1_count", {29'b0, fifo_count}, 32'd0);
      tick();
      check_bubble("t3_empty");
      check("t3_empty_pc", imem_addr, 32'h10);
      check("t3_empty_state", {30'b0, fsm_state}, {30'b0, S_EXT});

      // T4 FIFO full while stalled
      fetch_stall = 1'b1; ext_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         instr_ext = words[i];
         tick();
         check("t4_count", {29'b0, fifo_count}, (i < 4) ? 32'(i + 1) : 32'd4);
         check("t4_ready", {31'b0, ext_ready}, (i < 3) ? 32'd1 : 32'd0);
      end
      ext_valid = 1'b0;
      check("t4_no_issue", {31'b0, if_valid}, 32'd0);

      // T5 drain then switch back to memory
      fetch_stall = 1'b0;
      tick();
      check_issue("t5_w0", 32'h10, words[0]);
      tick();
      check_issue("t5_w1", 32'h14, words[1]);
      instr_mode = 1'b0;
      tick();
      check_issue("t5_w2", 32'h18, words[2]);
      tick();
      check_issue("t5_w3", 32'h1C, words[3]);
      check("t5_count", {29'b0, fifo_count}, 32'd0);
      tick();
      check_bubble("t5_b0");
      check("t5_b0_state", {30'b0, fsm_state}, {30'b0, S_SW});
      check("t5_b0_mode", {31'b0, cur_mode}, 32'd1);
      tick();
      check_bubble("t5_b1");
      check("t5_b1_state", {30'b0, fsm_state}, {30'b0, S_MEM});
      check("t5_b1_mode", {31'b0, cur_mode}, 32'd0);
      check("t5_b1_pc", imem_addr, 32'h20);
      tick();
      check_issue("t5_mem", 32'h20, 32'hA000_0020);

      // T6 flush beats stall
      flush = 1'b1; flush_pc = 32'h100; fetch_stall = 1'b1;
      tick();
      check_bubble("t6_flush");
      check("t6_flush_pc", imem_addr, 32'h100);
      check("t6_flush_if_pc", if_pc, 32'h20);
      flush = 1'b0; fetch_stall = 1'b0;
      tick();
      check_issue("t6_issue", 32'h100, 32'hA000_0100);

      // PC wrap at the top of the address space
      flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0;
      tick();
      check_issue("wrap_top", 32'hFFFF_FFFC, 32'h5FFF_FFFC);
      check("wrap_pc", imem_addr, 32'h0);
      tick();
      check_issue("wrap_zero", 32'h0, 32'h0050_0093);

      // Flush during SWITCH: redirect applies and the switch completes
      instr_mode = 1'b1;
      tick();
      check("swf_state", {30'b0, fsm_state}, {30'b0, S_SW});
      flush = 1'b1; flush_pc = 32'h200;
      tick();
      flush = 1'b0;
      check_bubble("swf");
      check("swf_state2", {30'b0, fsm_state}, {30'b0, S_EXT});
      check("swf_mode", {31'b0, cur_mode}, 32'd1);
      check("swf_pc", imem_addr, 32'h200);

      // Reset mid-operation discards FIFO contents
      fetch_stall = 1'b1; ext_valid = 1'b1; instr_ext = 32'h0080_0413;
      tick();
      ext_valid = 1'b0;
      check("rst_pre_count", {29'b0, fifo_count}, 32'd1);
      reset = 1'b1;
      #2;
      check("rst_count", {29'b0, fifo_count}, 32'd0);
      check("rst_ready", {31'b0, ext_ready}, 32'd1);
      check("rst_state", {30'b0, fsm_state}, {30'b0, S_MEM});
      check("rst_mode", {31'b0, cur_mode}, 32'd0);
      check("rst_pc", imem_addr, 32'h0);
      check_bubble("rst");
      reset = 1'b0; fetch_stall = 1'b0; instr_mode = 1'b0;
      tick();
      check_issue("rst_issue", 32'h0, 32'h0050_0093);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
